btb_update_ctrl: RTL and testbench

Write-port controller for the four-entry branch target buffer. It accepts branch-resolution updates from the EX stage, queues them, and writes them into the BTB one per cycle. On request it also runs a full-table invalidation sweep. It sits between the EX/MEM branch-resolution logic and the BTB write port, and is the only block that drives BTB writes.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/btb_update_fifo.sv | 55 +++++
 rtl/btb_update_ctrl.sv | 114 +++++++++++
 tb/tb_btb_update_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Types and constants shared by the BTB and its write-port controller.
package cpu_types_pkg;

  localparam int BTB_IDX_W = 2;
  localparam int BTB_TAG_W = 30 - BTB_IDX_W;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_IDX_W-1:0] idx;
    logic [31:0]          target;
  } btb_update_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } btbctrl_state_t;

endpackage

// File: rtl/btb_update_fifo.sv
// Small synchronous FIFO of pending BTB updates; head is read combinationally
// so the controller can write and pop in the same cycle.
module btb_update_fifo
  import cpu_types_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int PTR_W  = $clog2(QDEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  btb_update_t      wdata,
  output btb_update_t      head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  btb_update_t      mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(QDEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because QDEPTH is a power of two.
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !clear) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port controller: queues mispredict updates from EX and writes them
// one per cycle, or sweeps every entry invalid on request.
module btb_update_ctrl
  import cpu_types_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int IDX_W  = BTB_IDX_W,
  parameter int TAG_W  = BTB_TAG_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ex_valid,
  input  logic             ex_mispredict,
  input  logic             ex_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             inv_all,
  output logic             stall_ex,
  output logic             btb_wen,
  output logic [IDX_W-1:0] btb_widx,
  output logic [TAG_W-1:0] btb_wtag,
  output logic [31:0]      btb_wtarget,
  output logic             btb_wvalid,
  output logic             busy,
  output logic             inv_done
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  btbctrl_state_t   state_q;
  logic [IDX_W-1:0] sweep_cnt_q;
  logic             sweeping, sweep_last;
  logic             fifo_push, fifo_pop, fifo_clear;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  btb_update_t      rec, head;
  logic [1:0]       unused_pc_lsbs;

  assign unused_pc_lsbs = ex_pc[1:0];

  assign sweeping   = (state_q == SWEEP);
  assign sweep_last = (sweep_cnt_q == {IDX_W{1'b1}});
  assign stall_ex   = fifo_full | sweeping;
  assign busy       = (fifo_count != '0) | sweeping;

  // inv_all in IDLE wins over both the incoming update and the head write.
  assign fifo_clear = ~sweeping & inv_all;
  assign fifo_push  = ex_valid & ex_mispredict & ~stall_ex & ~inv_all;
  assign fifo_pop   = ~sweeping & ~inv_all & ~fifo_empty;

  always_comb begin
    rec        = '0;
    rec.valid  = ex_taken;
    rec.tag    = ex_pc[31:IDX_W+2];
    rec.idx    = ex_pc[IDX_W+1:2];
    rec.target = ex_target;
  end

  btb_update_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (fifo_clear),
    .wdata (rec),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      sweep_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inv_all) begin
            state_q     <= SWEEP;
            sweep_cnt_q <= '0;
          end
        end
        SWEEP: begin
          sweep_cnt_q <= sweep_cnt_q + IDX_W'(1);
          if (sweep_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write-port fields are forced to zero whenever no write is strobed.
  always_comb begin
    btb_wen     = 1'b0;
    btb_widx    = '0;
    btb_wtag    = '0;
    btb_wtarget = '0;
    btb_wvalid  = 1'b0;
    inv_done    = 1'b0;
    if (sweeping) begin
      btb_wen  = 1'b1;
      btb_widx = sweep_cnt_q;
      inv_done = sweep_last;
    end else if (fifo_pop) begin
      btb_wen     = 1'b1;
      btb_widx    = head.idx;
      btb_wtag    = head.tag;
      btb_wtarget = head.target;
      btb_wvalid  = head.valid;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed table-driven bench for btb_update_ctrl plus a few hand sequences.
module tb_btb_update_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, ex_mispredict, ex_taken, inv_all;
  logic [31:0] ex_pc, ex_target;
  logic        stall_ex, btb_wen, btb_wvalid, busy, inv_done;
  logic [1:0]  btb_widx;
  logic [27:0] btb_wtag;
  logic [31:0] btb_wtarget;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  btb_update_ctrl #(.QDEPTH(2), .IDX_W(2), .TAG_W(28)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ex_valid      (ex_valid),
    .ex_mispredict (ex_mispredict),
    .ex_taken      (ex_taken),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .inv_all       (inv_all),
    .stall_ex      (stall_ex),
    .btb_wen       (btb_wen),
    .btb_widx      (btb_widx),
    .btb_wtag      (btb_wtag),
    .btb_wtarget   (btb_wtarget),
    .btb_wvalid    (btb_wvalid),
    .busy          (busy),
    .inv_done      (inv_done)
  );

  // Output vector: {stall, wen, widx, wtag, wtarget, wvalid, busy, inv_done}
  logic [66:0] act;
  assign act = {stall_ex, btb_wen, btb_widx, btb_wtag, btb_wtarget, btb_wvalid, busy, inv_done};

  function automatic logic [66:0] outs(input logic st, input logic we, input logic [1:0] ix,
                                       input logic [27:0] tg, input logic [31:0] ta,
                                       input logic wv, input logic bs, input logic dn);
    return {st, we, ix, tg, ta, wv, bs, dn};
  endfunction

  typedef struct {
    string       name;
    logic        rst, v, m, t;
    logic [31:0] pc, tgt;
    logic        inv;
    logic [66:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic rst, input logic v, input logic m,
                              input logic t, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic inv, input logic [66:0] exp);
    vec_t r;
    r.name = name; r.rst = rst; r.v = v; r.m = m; r.t = t;
    r.pc = pc; r.tgt = tgt; r.inv = inv; r.exp = exp;
    vecs.push_back(r);
  endfunction

  task automatic drive(input logic rst, input logic v, input logic m, input logic t,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic inv);
    RST = rst; ex_valid = v; ex_mispredict = m; ex_taken = t;
    ex_pc = pc; ex_target = tgt; inv_all = inv;
  endtask

  task automatic check(input string name, input logic [66:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end else begin
      $display("ok   %s: outs=%h", name, act);
    end
  endtask

  localparam logic [66:0] Z = '0;

  initial begin
    int n;

    // Reset held for two edges, then ten quiet cycles.
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 check($sformatf("reset_idle%0d", i), Z);
      @(negedge CLK);
    end

    // Single taken mispredict, correct prediction, not-taken mispredict.
    add("tk_accept",  0, 1, 1, 1, 32'h48, 32'h100, 0, Z);
    add("tk_write",   0, 0, 0, 0, 0, 0, 0, outs(0, 1, 2'd2, 28'h4, 32'h100, 1, 1, 0));
    add("tk_after",   0, 0, 0, 0, 0, 0, 0, Z);
    add("hit_noq",    0, 1, 0, 1, 32'h80, 32'h999, 0, Z);
    add("hit_nowr",   0, 0, 0, 0, 0, 0, 0, Z);
    add("nt_accept",  0, 1, 1, 0, 32'hC, 32'h200, 0, Z);
    add("nt_write",   0, 0, 0, 0, 0, 0, 0, outs(0, 1, 2'd3, 28'h0, 32'h200, 0, 1, 0));
    add("nt_after",   0, 0, 0, 0, 0, 0, 0, Z);
    // Three back-to-back mispredicts: each pop overlaps the next push.
    add("b2b_a",      0, 1, 1, 1, 32'h10, 32'h1000, 0, Z);
    add("b2b_b",      0, 1, 1, 1, 32'h24, 32'h2000, 0, outs(0, 1, 2'd0, 28'h1, 32'h1000, 1, 1, 0));
    add("b2b_c",      0, 1, 1, 1, 32'h38, 32'h3000, 0, outs(0, 1, 2'd1, 28'h2, 32'h2000, 1, 1, 0));
    add("b2b_wc",     0, 0, 0, 0, 0, 0, 0, outs(0, 1, 2'd2, 28'h3, 32'h3000, 1, 1, 0));
    add("b2b_after",  0, 0, 0, 0, 0, 0, 0, Z);
    // Sweep with a queued record and a simultaneous update, both discarded.
    add("sw_queue",   0, 1, 1, 1, 32'h4, 32'h4000, 0, Z);
    add("sw_req",     0, 1, 1, 1, 32'h8, 32'h5000, 1, outs(0, 0, 2'd0, 0, 0, 0, 1, 0));
    add("sw_0",       0, 0, 0, 0, 0, 0, 0, outs(1, 1, 2'd0, 0, 0, 0, 1, 0));
    add("sw_1_ign",   0, 1, 1, 1, 32'h14, 32'h6000, 1, outs(1, 1, 2'd1, 0, 0, 0, 1, 0));
    add("sw_2",       0, 0, 0, 0, 0, 0, 0, outs(1, 1, 2'd2, 0, 0, 0, 1, 0));
    add("sw_3_done",  0, 0, 0, 0, 0, 0, 0, outs(1, 1, 2'd3, 0, 0, 0, 1, 1));
    add("sw_after0",  0, 0, 0, 0, 0, 0, 0, Z);
    add("sw_after1",  0, 0, 0, 0, 0, 0, 0, Z);
    // Reset in the second sweep cycle aborts it.
    add("rs_req",     0, 0, 0, 0, 0, 0, 1, Z);
    add("rs_sw0",     0, 0, 0, 0, 0, 0, 0, outs(1, 1, 2'd0, 0, 0, 0, 1, 0));
    add("rs_sw1_rst", 1, 0, 0, 0, 0, 0, 0, outs(1, 1, 2'd1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 5; i++) add($sformatf("rs_quiet%0d", i), 0, 0, 0, 0, 0, 0, 0, Z);
    // Reset also empties the queue.
    add("rq_push",    0, 1, 1, 1, 32'h2C, 32'h7000, 0, Z);
    add("rq_rst",     1, 0, 0, 0, 0, 0, 0, outs(0, 1, 2'd3, 28'h2, 32'h7000, 1, 1, 0));
    add("rq_after0",  0, 0, 0, 0, 0, 0, 0, Z);
    add("rq_after1",  0, 0, 0, 0, 0, 0, 0, Z);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].m, vecs[i].t, vecs[i].pc, vecs[i].tgt, vecs[i].inv);
      #1 check(vecs[i].name, vecs[i].exp);
      @(negedge CLK);
    end

    // Latency: an accepted update must be written in the very next cycle.
    drive(0, 1, 1, 1, 32'h3C, 32'h5555, 0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n = 0;
    while (!btb_wen && n < 8) begin
      @(negedge CLK);
      #1;
      n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL lat_wait: got=%0d extra cycles want=0", n);
    end else begin
      $display("ok   lat_wait: write in next cycle");
    end
    check("lat_write", outs(0, 1, 2'd3, 28'h3, 32'h5555, 1, 1, 0));
    @(negedge CLK);
    #1 check("lat_after", Z);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
